// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared types and scan-code constants for the PS/2 Set-2 decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

endpackage

// File: rtl/ps2_scancode_decoder_ascii_lut.sv
// Combinational Set-2 scan code to ASCII translation for letters, digits,
// space, enter and backspace. Extended codes never map to a character.
module ps2_ascii_lut (
  input  logic [7:0] code_i,
  input  logic       ext_i,
  input  logic       shift_i,
  output logic [7:0] ascii_o
);

  logic [7:0] base;
  logic       is_letter;

  // Lowercase/base character lookup; shift only affects letters.
  always_comb begin
    base      = 8'h00;
    is_letter = 1'b0;
    case (code_i)
      8'h1C: begin base = 8'h61; is_letter = 1'b1; end // a
      8'h32: begin base = 8'h62; is_letter = 1'b1; end // b
      8'h21: begin base = 8'h63; is_letter = 1'b1; end // c
      8'h23: begin base = 8'h64; is_letter = 1'b1; end // d
      8'h24: begin base = 8'h65; is_letter = 1'b1; end // e
      8'h2B: begin base = 8'h66; is_letter = 1'b1; end // f
      8'h34: begin base = 8'h67; is_letter = 1'b1; end // g
      8'h33: begin base = 8'h68; is_letter = 1'b1; end // h
      8'h43: begin base = 8'h69; is_letter = 1'b1; end // i
      8'h3B: begin base = 8'h6A; is_letter = 1'b1; end // j
      8'h42: begin base = 8'h6B; is_letter = 1'b1; end // k
      8'h4B: begin base = 8'h6C; is_letter = 1'b1; end // l
      8'h3A: begin base = 8'h6D; is_letter = 1'b1; end // m
      8'h31: begin base = 8'h6E; is_letter = 1'b1; end // n
      8'h44: begin base = 8'h6F; is_letter = 1'b1; end // o
      8'h4D: begin base = 8'h70; is_letter = 1'b1; end // p
      8'h15: begin base = 8'h71; is_letter = 1'b1; end // q
      8'h2D: begin base = 8'h72; is_letter = 1'b1; end // r
      8'h1B: begin base = 8'h73; is_letter = 1'b1; end // s
      8'h2C: begin base = 8'h74; is_letter = 1'b1; end // t
      8'h3C: begin base = 8'h75; is_letter = 1'b1; end // u
      8'h2A: begin base = 8'h76; is_letter = 1'b1; end // v
      8'h1D: begin base = 8'h77; is_letter = 1'b1; end // w
      8'h22: begin base = 8'h78; is_letter = 1'b1; end // x
      8'h35: begin base = 8'h79; is_letter = 1'b1; end // y
      8'h1A: begin base = 8'h7A; is_letter = 1'b1; end // z
      8'h45: base = 8'h30; // 0
      8'h16: base = 8'h31; // 1
      8'h1E: base = 8'h32; // 2
      8'h26: base = 8'h33; // 3
      8'h25: base = 8'h34; // 4
      8'h2E: base = 8'h35; // 5
      8'h36: base = 8'h36; // 6
      8'h3D: base = 8'h37; // 7
      8'h3E: base = 8'h38; // 8
      8'h46: base = 8'h39; // 9
      8'h29: base = 8'h20; // space
      8'h5A: base = 8'h0D; // enter
      8'h66: base = 8'h08; // backspace
      default: begin
        base      = 8'h00;
        is_letter = 1'b0;
      end
    endcase
  end

  // Extended keys share codes with letters, so they are forced to 0x00.
  always_comb begin
    ascii_o = base;
    if (ext_i) begin
      ascii_o = 8'h00;
    end else if (is_letter && shift_i) begin
      ascii_o = base - 8'h20;
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pops Set-2 bytes from the PS/2 receiver FIFO, folds F0/E0 prefixes into
// flags and emits one registered key event per non-prefix byte, tracking
// the held key, typematic repeats, shift state and a press counter.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_ready,
  output logic             nextdata_n,
  output logic             ev_valid,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             ev_repeat,
  output logic [7:0]       ascii,
  output logic             key_down,
  output logic             shift,
  output logic [CNT_W-1:0] press_count
);

  state_t           state_q;
  logic [7:0]       byte_q;
  logic             brk_f_q;
  logic             ext_f_q;
  logic [7:0]       held_code_q;
  logic             held_ext_q;
  logic             held_v_q;
  logic             lsh_q;
  logic             rsh_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             nd_q;
  logic             ev_valid_q;
  logic [7:0]       ev_code_q;
  logic             ev_ext_q;
  logic             ev_break_q;
  logic             ev_repeat_q;
  logic [7:0]       ascii_q;

  logic             shift_w;
  logic             same_held;
  logic [7:0]       ascii_w;

  assign shift_w   = lsh_q | rsh_q;
  assign same_held = held_v_q && (held_code_q == byte_q) && (held_ext_q == ext_f_q);
  assign cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Shift is taken as it stands before the current byte is applied.
  ps2_ascii_lut u_lut (
    .code_i  (byte_q),
    .ext_i   (ext_f_q),
    .shift_i (shift_w),
    .ascii_o (ascii_w)
  );

  // Handshake FSM plus byte decode; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_q      <= 8'h00;
      brk_f_q     <= 1'b0;
      ext_f_q     <= 1'b0;
      held_code_q <= 8'h00;
      held_ext_q  <= 1'b0;
      held_v_q    <= 1'b0;
      lsh_q       <= 1'b0;
      rsh_q       <= 1'b0;
      cnt_q       <= '0;
      nd_q        <= 1'b1;
      ev_valid_q  <= 1'b0;
      ev_code_q   <= 8'h00;
      ev_ext_q    <= 1'b0;
      ev_break_q  <= 1'b0;
      ev_repeat_q <= 1'b0;
      ascii_q     <= 8'h00;
    end else begin
      ev_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ps2_ready) begin
            byte_q  <= ps2_data;
            nd_q    <= 1'b0;
            state_q <= ACK;
          end
        end
        ACK: begin
          nd_q    <= 1'b1;
          state_q <= SETTLE;
          if (byte_q == SC_BREAK) begin
            brk_f_q <= 1'b1;
          end else if (byte_q == SC_EXT) begin
            ext_f_q <= 1'b1;
          end else begin
            ev_valid_q <= 1'b1;
            ev_code_q  <= byte_q;
            ev_ext_q   <= ext_f_q;
            ev_break_q <= brk_f_q;
            ascii_q    <= ascii_w;
            brk_f_q    <= 1'b0;
            ext_f_q    <= 1'b0;
            if (brk_f_q) begin
              ev_repeat_q <= 1'b0;
              if (same_held) held_v_q <= 1'b0;
              if (!ext_f_q && byte_q == SC_LSHIFT) lsh_q <= 1'b0;
              if (!ext_f_q && byte_q == SC_RSHIFT) rsh_q <= 1'b0;
            end else begin
              if (same_held) begin
                ev_repeat_q <= 1'b1;
              end else begin
                ev_repeat_q <= 1'b0;
                held_code_q <= byte_q;
                held_ext_q  <= ext_f_q;
                held_v_q    <= 1'b1;
                cnt_q       <= cnt_d;
              end
              if (!ext_f_q && byte_q == SC_LSHIFT) lsh_q <= 1'b1;
              if (!ext_f_q && byte_q == SC_RSHIFT) rsh_q <= 1'b1;
            end
          end
        end
        SETTLE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign nextdata_n  = nd_q;
  assign ev_valid    = ev_valid_q;
  assign ev_code     = ev_code_q;
  assign ev_ext      = ev_ext_q;
  assign ev_break    = ev_break_q;
  assign ev_repeat   = ev_repeat_q;
  assign ascii       = ascii_q;
  assign key_down    = held_v_q;
  assign shift       = shift_w;
  assign press_count = cnt_q;

endmodule
